// File: rtl/ysyx_22040759_store_buf_if.sv
// Store-buffer bus bundle: MEM-stage store/load side plus the AXI write-master side.
// The master modport is the core/write-master side, and the slave modport is the buffer.
interface ysyx_22040759_store_buf_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              st_valid_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic [2:0]        st_size_i;
  logic [DATA_W-1:0] st_data_i;
  logic              st_ready_o;
  logic              wr_addr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [2:0]        wr_size_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_data_valid_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_conflict_o;
  logic              sb_empty_o;

  modport master (
    output st_valid_i, st_addr_i, st_size_i, st_data_i, wr_data_valid_i, ld_addr_i,
    input  st_ready_o, wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o, ld_conflict_o, sb_empty_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_size_i, st_data_i, wr_data_valid_i, ld_addr_i,
    output st_ready_o, wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o, ld_conflict_o, sb_empty_o
  );
endinterface

// File: rtl/ysyx_22040759_store_buf.sv
// In-order store buffer: queues MEM-stage stores and drains them one at a time to the
// AXI write master; flags loads that hit a pending store doubleword.
module ysyx_22040759_store_buf #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22040759_store_buf_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [2:0]        size_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              full_c;
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] mask_c;
  logic              conflict_c;
  logic [PTR_W-1:0]  off_c;

  assign full_c = (count == CNT_W'(DEPTH));
  assign push_c = bus.st_valid_i && !full_c;
  assign pop_c  = (state == WAIT) && bus.wr_data_valid_i;

  // Size-dependent data mask applied at push time
  always_comb begin
    mask_c = '1;
    case (bus.st_size_i)
      3'd0:    mask_c = DATA_W'(64'h0000_0000_0000_00FF);
      3'd1:    mask_c = DATA_W'(64'h0000_0000_0000_FFFF);
      3'd2:    mask_c = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: mask_c = '1;
    endcase
  end

  // Entry storage carries no reset; validity comes from head/count
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[tail] <= bus.st_addr_i;
      size_q[tail] <= bus.st_size_i;
      data_q[tail] <= bus.st_data_i & mask_c;
    end
  end

  // Pointers, occupancy and drain FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (push_c) tail <= tail + PTR_W'(1);
      if (pop_c)  head <= head + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE:    if (count != '0) state <= REQ;
        REQ:     state <= WAIT;
        WAIT:    if (bus.wr_data_valid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Doubleword overlap against every occupied slot, in-flight head included
  always_comb begin
    conflict_c = 1'b0;
    off_c      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_c = PTR_W'(i) - head;
      if (({1'b0, off_c} < count) && (((addr_q[i] ^ bus.ld_addr_i) >> 3) == '0))
        conflict_c = 1'b1;
    end
  end

  assign bus.st_ready_o      = !full_c;
  assign bus.wr_addr_valid_o = (state == REQ);
  assign bus.wr_addr_o       = addr_q[head];
  assign bus.wr_size_o       = size_q[head];
  assign bus.wr_data_o       = data_q[head];
  assign bus.ld_conflict_o   = conflict_c;
  assign bus.sb_empty_o      = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_ysyx_22040759_store_buf.sv
// Scoreboard bench for the store buffer: every accepted store is queued with its
// masked payload and matched against each wr_addr_valid_o issue.
module tb_ysyx_22040759_store_buf;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_22040759_store_buf_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  ysyx_22040759_store_buf #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  int   pulses  = 0;
  ent_t expq[$];
  bit   in_flight = 1'b0;
  ent_t cur;

  function automatic logic [DW-1:0] model_mask(input logic [2:0] s, input logic [DW-1:0] d);
    case (s)
      3'd0:    return {56'b0, d[7:0]};
      3'd1:    return {48'b0, d[15:0]};
      3'd2:    return {32'b0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Issue monitor: scoreboard match on each pulse, payload hold while outstanding
  always @(negedge clk) begin : mon
    ent_t got;
    ent_t exp;
    got = {bus.wr_addr_o, bus.wr_size_o, bus.wr_data_o};
    if (!rst_n) begin
      in_flight = 1'b0;
    end else if (bus.wr_addr_valid_o === 1'b1) begin
      pulses++;
      vectors++;
      if (in_flight) begin
        errors++;
        $display("FAIL issue_overlap: pulse at addr %h while previous store outstanding, required none", got.addr);
      end
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got addr %h, required no issue", got.addr);
      end else begin
        exp = expq.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL issue_payload: got %h/%0d/%h, required %h/%0d/%h",
                   got.addr, got.size, got.data, exp.addr, exp.size, exp.data);
        end
      end
      cur       = got;
      in_flight = 1'b1;
    end else if (in_flight) begin
      vectors++;
      if (got !== cur) begin
        errors++;
        $display("FAIL issue_hold: got %h/%0d/%h, required %h/%0d/%h",
                 got.addr, got.size, got.data, cur.addr, cur.size, cur.data);
      end
      if (bus.wr_data_valid_i === 1'b1) in_flight = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [2:0] s, input logic [DW-1:0] d,
                      input bit accept);
    bus.st_valid_i = 1'b1;
    bus.st_addr_i  = a;
    bus.st_size_i  = s;
    bus.st_data_i  = d;
    if (accept) expq.push_back({a, s, model_mask(s, d)});
    tick();
    bus.st_valid_i = 1'b0;
  endtask

  task automatic done();
    bus.wr_data_valid_i = 1'b1;
    tick();
    bus.wr_data_valid_i = 1'b0;
  endtask

  task automatic wait_pulse(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (bus.wr_addr_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain(input int n, output int got);
    bit ok;
    got = 0;
    for (int i = 0; i < n; i++) begin
      wait_pulse(20, ok);
      if (!ok) break;
      tick();
      done();
      got++;
    end
  endtask

  task automatic test_reset();
    bus.st_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_size_i = '0; bus.st_data_i = '0;
    bus.wr_data_valid_i = 1'b0; bus.ld_addr_i = '0;
    rst_n = 1'b0;
    tick();
    tick();
    vectors += 4;
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.st_ready_o); end
    if (bus.wr_addr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.wr_addr_valid_o); end
    if (bus.ld_conflict_o !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b, required 0", bus.ld_conflict_o); end
    if (bus.sb_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", bus.sb_empty_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push(64'h8000_0004, 3'd2, 64'hFFFF_FFFF_1234_5678, 1'b1);
    vectors += 2;
    if (bus.wr_addr_valid_o !== 1'b0) begin errors++; $display("FAIL single_early: valid got %b, required 0", bus.wr_addr_valid_o); end
    if (bus.sb_empty_o !== 1'b0) begin errors++; $display("FAIL single_busy: empty got %b, required 0", bus.sb_empty_o); end
    tick();
    vectors += 4;
    if (bus.wr_addr_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency: valid got %b, required 1", bus.wr_addr_valid_o); end
    if (bus.wr_addr_o !== 64'h8000_0004) begin errors++; $display("FAIL single_addr: got %h, required 80000004", bus.wr_addr_o); end
    if (bus.wr_size_o !== 3'd2) begin errors++; $display("FAIL single_size: got %0d, required 2", bus.wr_size_o); end
    if (bus.wr_data_o !== 64'h1234_5678) begin errors++; $display("FAIL single_data: got %h, required 12345678", bus.wr_data_o); end
    tick();
    vectors += 1;
    if (bus.wr_addr_valid_o !== 1'b0) begin errors++; $display("FAIL single_pulse_width: valid got %b, required 0", bus.wr_addr_valid_o); end
    tick();
    tick();
    vectors += 1;
    if (bus.sb_empty_o !== 1'b0) begin errors++; $display("FAIL single_wait: empty got %b, required 0", bus.sb_empty_o); end
    done();
    vectors += 1;
    if (bus.sb_empty_o !== 1'b1) begin errors++; $display("FAIL single_drained: empty got %b, required 1", bus.sb_empty_o); end
  endtask

  task automatic test_ignore_done();
    push(64'h8000_0200, 3'd1, 64'hDEAD_BEEF_ABCD_1234, 1'b1);
    done();
    vectors += 1;
    if (bus.wr_addr_valid_o !== 1'b1) begin errors++; $display("FAIL idle_done: valid got %b, required 1", bus.wr_addr_valid_o); end
    done();
    vectors += 2;
    if (bus.sb_empty_o !== 1'b0) begin errors++; $display("FAIL req_done: empty got %b, required 0", bus.sb_empty_o); end
    if (bus.wr_addr_valid_o !== 1'b0) begin errors++; $display("FAIL req_done_valid: got %b, required 0", bus.wr_addr_valid_o); end
    tick();
    done();
    vectors += 1;
    if (bus.sb_empty_o !== 1'b1) begin errors++; $display("FAIL ignore_drained: empty got %b, required 1", bus.sb_empty_o); end
  endtask

  task automatic test_conflict();
    bit ok;
    bus.ld_addr_i  = 64'h8000_0016;
    bus.st_valid_i = 1'b1;
    bus.st_addr_i  = 64'h8000_0010;
    bus.st_size_i  = 3'd3;
    bus.st_data_i  = 64'h0123_4567_89AB_CDEF;
    expq.push_back({64'h8000_0010, 3'd3, 64'h0123_4567_89AB_CDEF});
    #1;
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b0) begin errors++; $display("FAIL conflict_incoming: got %b, required 0", bus.ld_conflict_o); end
    tick();
    bus.st_valid_i = 1'b0;
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b1) begin errors++; $display("FAIL conflict_hit: got %b, required 1", bus.ld_conflict_o); end
    bus.ld_addr_i = 64'h8000_0018;
    #1;
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b0) begin errors++; $display("FAIL conflict_next_dw: got %b, required 0", bus.ld_conflict_o); end
    bus.ld_addr_i = 64'h8000_0016;
    wait_pulse(20, ok);
    vectors += 1;
    if (!ok) begin errors++; $display("FAIL conflict_issue: no pulse, required one"); end
    tick();
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b1) begin errors++; $display("FAIL conflict_inflight: got %b, required 1", bus.ld_conflict_o); end
    done();
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b0) begin errors++; $display("FAIL conflict_after_pop: got %b, required 0", bus.ld_conflict_o); end
    bus.ld_addr_i = '0;
  endtask

  task automatic test_full_and_simul();
    bit ok;
    int got;
    for (int i = 0; i < 4; i++)
      push(64'h8000_1000 + 64'(8 * i), 3'd3, 64'h1111_0000_0000_0000 + 64'(i), 1'b1);
    vectors += 1;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", bus.st_ready_o); end
    push(64'h8000_1FF0, 3'd3, 64'h5555, 1'b0);
    vectors += 1;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL full_reject: ready got %b, required 0", bus.st_ready_o); end
    done();
    vectors += 1;
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b, required 1", bus.st_ready_o); end
    wait_pulse(20, ok);
    vectors += 1;
    if (!ok || bus.wr_addr_o !== 64'h8000_1008)
      begin errors++; $display("FAIL full_next_entry: got %h (pulse %b), required 80001008", bus.wr_addr_o, ok); end
    tick();
    push(64'h8000_1020, 3'd0, 64'hFFFF_FFFF_FFFF_FF7E, 1'b1);
    vectors += 1;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL refill_ready: got %b, required 0", bus.st_ready_o); end
    // Push and completion in the same cycle while full
    bus.st_valid_i = 1'b1; bus.st_addr_i = 64'h8000_1FF8; bus.st_size_i = 3'd3; bus.st_data_i = 64'h7777;
    bus.wr_data_valid_i = 1'b1;
    tick();
    bus.st_valid_i = 1'b0;
    bus.wr_data_valid_i = 1'b0;
    vectors += 1;
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL simul_count: ready got %b, required 1", bus.st_ready_o); end
    drain(3, got);
    vectors += 2;
    if (got != 3) begin errors++; $display("FAIL full_drain: got %0d issues, required 3", got); end
    if (bus.sb_empty_o !== 1'b1 || expq.size() != 0)
      begin errors++; $display("FAIL full_empty: empty %b queue %0d, required 1 and 0", bus.sb_empty_o, expq.size()); end
  endtask

  task automatic test_back_to_back();
    int p0;
    bit prod_to;
    bit cons_to;
    p0 = pulses;
    prod_to = 1'b0;
    cons_to = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int n;
          n = 0;
          while (bus.st_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
          if (n >= 100) begin prod_to = 1'b1; break; end
          push(64'h8000_2000 + 64'(16 * i) + 64'(i), 3'(i % 4), {$urandom, $urandom}, 1'b1);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          bit ok;
          wait_pulse(100, ok);
          if (!ok) begin cons_to = 1'b1; break; end
          tick();
          repeat ($urandom_range(0, 5)) tick();
          done();
        end
      end
    join
    vectors += 3;
    if (prod_to || cons_to) begin errors++; $display("FAIL b2b_timeout: producer %b consumer %b, required 0 0", prod_to, cons_to); end
    if (pulses - p0 != 6) begin errors++; $display("FAIL b2b_pulses: got %0d, required 6", pulses - p0); end
    if (bus.sb_empty_o !== 1'b1 || expq.size() != 0)
      begin errors++; $display("FAIL b2b_empty: empty %b queue %0d, required 1 and 0", bus.sb_empty_o, expq.size()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      push(64'h8000_0100 + 64'(8 * i), 3'd3, 64'hCAFE_0000 + 64'(i), 1'b1);
    tick();
    vectors += 1;
    if (bus.sb_empty_o !== 1'b0) begin errors++; $display("FAIL mid_busy: empty got %b, required 0", bus.sb_empty_o); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expq.delete();
    vectors += 3;
    if (bus.sb_empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b, required 1", bus.sb_empty_o); end
    if (bus.wr_addr_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", bus.wr_addr_valid_o); end
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", bus.st_ready_o); end
    bus.ld_addr_i = 64'h8000_0108;
    #1;
    vectors += 1;
    if (bus.ld_conflict_o !== 1'b0) begin errors++; $display("FAIL mid_conflict: got %b, required 0", bus.ld_conflict_o); end
    done();
    vectors += 1;
    if (bus.sb_empty_o !== 1'b1) begin errors++; $display("FAIL mid_late_done: empty got %b, required 1", bus.sb_empty_o); end
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (bus.wr_addr_valid_o === 1'b1) seen = 1'b1;
        tick();
      end
      vectors += 1;
      if (seen) begin errors++; $display("FAIL mid_no_issue: pulse seen %b, required 0", seen); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore_done();
    test_conflict();
    test_full_and_simul();
    test_back_to_back();
    test_reset_mid();
    vectors += 1;
    if (expq.size() != 0) begin errors++; $display("FAIL final_queue: %0d stores never issued, required 0", expq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
